dff_share_arbiter: RTL and testbench
====================================

Name: dff_share_arbiter

Overview:
- Round-robin arbiter and sequencer for one shared, triplication-target data register (the voted DFF resource).
- N requesters compete for the register's single write port. The winner's data is captured into q, and the winner receives a one-cycle grant.
- An optional scrub scheduler periodically rewrites q with its own value, so that after triplication the voters refresh all three copies.
- All state is triplicated under the default triplicate directive.

Parameters:
- N, 4, number of requesters (2..16).
- W, 8, data width of each requester and of q.
- SCRUB_PERIOD, 16, scrub interval in clock cycles (≥2). Used only with SCRUB_EN.

Ports:
- c  input  1  clock, rising edge.
- r  input  1  reset, asynchronous, active-high.
- req  input  N  request vector; bit i belongs to requester i.
- d  input  N*W  packed data; requester i uses d[i*W +: W].
- gnt  output  N  registered one-hot grant pulse; all zeros when idle.
- q  output  W  shared register contents.
- q_vld  output  1  set after the first granted write; sticky until reset.
- scrub  output  1  one-cycle pulse marking a scrub cycle. Constant 0 without SCRUB_EN.
- st  output  2  current state: 0 IDLE, 1 GRANT, 2 SCRUB.

Behaviour:
- Reset (r=1, asynchronous): q=0, gnt=0, q_vld=0, scrub=0, st=IDLE, ptr=0, scrub_cnt=0, pending=0.
- State register st records the action taken at the last edge. Next state is evaluated every edge, in this priority:
  - SCRUB, if pending=1 (SCRUB_EN only): q holds its value (q<=q), gnt<=0, scrub<=1, pending<=0. Requests wait.
  - GRANT, if |req: the winner is the first set bit at or after ptr, searching upward and wrapping mod N. Then q<=d[winner], gnt<=onehot(winner), q_vld<=1, ptr<=(winner+1) mod N.
  - IDLE, otherwise: gnt<=0, scrub<=0, q holds, ptr holds.
- Latency: req sampled at edge k produces gnt and the new q visible after edge k, in the same cycle. gnt is never high for two consecutive cycles on the same bit unless that requester is the only one requesting.
- Handshake rules:
  - A requester holds req and d stable until it sees gnt=1.
  - It may drop req in the grant cycle.
  - If req is still high in the grant cycle, it is treated as a new request and re-arbitrated fairly.
- Fairness: with all N requesting continuously, the grant order is ptr, ptr+1, … with wrap. Each requester waits at most N-1 grant cycles, plus any scrub cycles.
- Scrub counter (SCRUB_EN only):
  - scrub_cnt counts every cycle from 0 to SCRUB_PERIOD-1, then wraps to 0.
  - At the wrap, pending<=1. Pending does not stack: a second wrap before service leaves it at 1.
  - Scrub has priority over requests. The counter is free-running and is not reset by the scrub.
- Simultaneous wrap and scrub service on the same edge: the service clears the old pending and the wrap sets it again, so pending=1 afterwards.
- Width: ptr is clog2(N) bits, and wrap is explicit for non-power-of-2 N. scrub_cnt is clog2(SCRUB_PERIOD) bits.
- Reset mid-grant or mid-scrub: all outputs return to reset values immediately, with no completion of the action in flight.

Optional Feature:
- Macro: DFF_SHARE_ARBITER_SCRUB_EN.
- Defined: scrub counter, pending flag and SCRUB state are present, and the scrub port pulses as specified.
- Undefined: no counter or pending logic is instantiated. scrub is tied to 0, st never takes value 2, and arbitration is pure round-robin.

Test Plan (N=4, W=8, SCRUB_PERIOD=8):
- Reset check: assert r mid-cycle with req=4'b1111 → q=0, gnt=0, q_vld=0 and st=0 immediately. First grant after release goes to requester 0.
- Single requester: req=4'b0100, d[2]=8'hA5 → after next edge gnt=4'b0100, q=8'hA5, q_vld=1. Requester drops req, so gnt=0 on the following cycle.
- Full contention: req=4'b1111 held, d[i]=8'h10+i → gnt sequence 0001, 0010, 0100, 1000, 0001. q follows 10, 11, 12, 13, 10.
- Wrap from non-zero ptr: last grant was requester 3, then req=4'b1001 → grant goes to 0 first, then 3.
- Scrub preemption (SCRUB_EN): req=4'b1111 held from reset → the first 8 edges grant, after which scrub=1 for one cycle with gnt=0 and q unchanged. Round-robin then resumes at the correct ptr, and scrub pulses again every 8 cycles.
- Scrub disabled build: the same stimulus gives uninterrupted round-robin, with scrub=0 and st never equal to 2.

Source files
------------

// File: rtl/dff_share_arbiter.sv
// dff_share_arbiter
// Round-robin arbiter that sequences N requesters onto one shared data
// register q. The winner's data is written into q, and the winner gets a
// one-cycle registered grant.
// Optional feature macro: DFF_SHARE_ARBITER_SCRUB_EN. When it is defined, a
// free-running scrub scheduler periodically rewrites q with its own value so
// that the voted copies of the register are refreshed. That scrub cycle
// preempts arbitration.
module dff_share_arbiter #(
    parameter int N            = 4,
    parameter int W            = 8,
    parameter int SCRUB_PERIOD = 16
) (
    input  logic           c,
    input  logic           r,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] d,
    output logic [N-1:0]   gnt,
    output logic [W-1:0]   q,
    output logic           q_vld,
    output logic           scrub,
    output logic [1:0]     st
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    // Reject configurations the arbiter and the scrub scheduler cannot support.
    if (N < 2 || N > 16 || SCRUB_PERIOD < 2) begin : gBadParam
        $error("dff_share_arbiter: unsupported N or SCRUB_PERIOD");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SCRUB = 2'd2
    } state_t;

    state_t        stateReg, stateNext;
    logic [PW-1:0] ptrReg, ptrNext;
    logic [PW-1:0] winner;
    logic [N-1:0]  gntReg, gntNext;
    logic [W-1:0]  qReg, qNext;
    logic          qVldReg, qVldNext;
    logic          pendingReg;

`ifdef DFF_SHARE_ARBITER_SCRUB_EN
    localparam int CW = $clog2(SCRUB_PERIOD);

    logic [CW-1:0] scrubCntReg;
    logic          scrubReg;
    logic          cntWrap;

    assign cntWrap = (scrubCntReg == CW'(SCRUB_PERIOD - 1));

    // Free-running scrub interval counter and pending flag. A pending scrub
    // always wins the very next edge, so pending never outlives one cycle
    // unless the wrap on the servicing edge sets it again.
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            scrubCntReg <= '0;
            pendingReg  <= 1'b0;
            scrubReg    <= 1'b0;
        end else begin
            scrubCntReg <= cntWrap ? '0 : scrubCntReg + 1'b1;
            pendingReg  <= cntWrap;
            scrubReg    <= (stateNext == SCRUB);
        end
    end

    assign scrub = scrubReg;
`else
    assign pendingReg = 1'b0;
    assign scrub      = 1'b0;
`endif

    // Round-robin search. Take the first request at or after ptr, wrapping mod N.
    always_comb begin
        int   idx;
        logic found;
        idx    = 0;
        found  = 1'b0;
        winner = ptrReg;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptrReg) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = PW'(idx);
            end
        end
    end

    // Next-state selection. A pending scrub beats any request.
    always_comb begin
        stateNext = IDLE;
        if (pendingReg) begin
            stateNext = SCRUB;
        end else if (|req) begin
            stateNext = GRANT;
        end
    end

    // Register updates implied by the action chosen for this edge.
    always_comb begin
        gntNext  = '0;
        qNext    = qReg;
        qVldNext = qVldReg;
        ptrNext  = ptrReg;
        unique case (stateNext)
            GRANT: begin
                gntNext[winner] = 1'b1;
                qNext           = d[int'(winner)*W +: W];
                qVldNext        = 1'b1;
                ptrNext         = (winner == PW'(N - 1)) ? '0 : winner + 1'b1;
            end
            default: begin
                // IDLE and SCRUB both leave q and ptr untouched.
            end
        endcase
    end

    // State, shared register and arbitration pointer.
    always_ff @(posedge c or posedge r) begin
        if (r) begin
            stateReg <= IDLE;
            ptrReg   <= '0;
            gntReg   <= '0;
            qReg     <= '0;
            qVldReg  <= 1'b0;
        end else begin
            stateReg <= stateNext;
            ptrReg   <= ptrNext;
            gntReg   <= gntNext;
            qReg     <= qNext;
            qVldReg  <= qVldNext;
        end
    end

    assign gnt   = gntReg;
    assign q     = qReg;
    assign q_vld = qVldReg;
    assign st    = stateReg;

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Testbench for dff_share_arbiter (N=4, W=8, SCRUB_PERIOD=8).
// Directed steps followed by randomized requests, all checked against a
// rule-level reference model (pointer, cycle count, pending flag).
module tb_dff_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int SP = 8;
`ifdef DFF_SHARE_ARBITER_SCRUB_EN
    localparam bit SCRUB_ON = 1'b1;
`else
    localparam bit SCRUB_ON = 1'b0;
`endif

    logic           c;
    logic           r;
    logic [N-1:0]   req;
    logic [N*W-1:0] d;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic           q_vld;
    logic           scrub;
    logic [1:0]     st;

    dff_share_arbiter #(.N(N), .W(W), .SCRUB_PERIOD(SP)) dut (
        .c(c), .r(r), .req(req), .d(d),
        .gnt(gnt), .q(q), .q_vld(q_vld), .scrub(scrub), .st(st)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int         mPtr;
    int         mCycles;
    bit         mPending;
    logic [3:0] mGnt;
    logic [7:0] mQ;
    logic       mQv;
    logic       mScrub;
    logic [1:0] mSt;

    task modelReset();
        mPtr = 0; mCycles = 0; mPending = 0;
        mGnt = '0; mQ = '0; mQv = 1'b0; mScrub = 1'b0; mSt = 2'd0;
    endtask

    // One clock edge of the arbitration rules, using the inputs as sampled.
    task modelEdge();
        int w;
        bit wrapNow;
        wrapNow = SCRUB_ON && ((mCycles % SP) == SP - 1);
        mCycles++;
        if (SCRUB_ON && mPending) begin
            mSt = 2'd2; mGnt = '0; mScrub = 1'b1;
        end else if (req != '0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && req[(mPtr + k) % N]) w = (mPtr + k) % N;
            end
            mGnt = 4'(1 << w);
            mQ = d[w*W +: W];
            mQv = 1'b1;
            mPtr = (w + 1) % N;
            mSt = 2'd1;
            mScrub = 1'b0;
        end else begin
            mSt = 2'd0; mGnt = '0; mScrub = 1'b0;
        end
        mPending = wrapNow;
    endtask

    task check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task checkAll(input string tag);
        check({tag, ".gnt"},   32'(gnt),   32'(mGnt));
        check({tag, ".q"},     32'(q),     32'(mQ));
        check({tag, ".q_vld"}, 32'(q_vld), 32'(mQv));
        check({tag, ".st"},    32'(st),    32'(mSt));
        check({tag, ".scrub"}, 32'(scrub), 32'(mScrub));
        $display("%0t %s req=%b gnt=%b q=%h q_vld=%b st=%0d scrub=%b", $time, tag, req, gnt, q, q_vld, st, scrub);
    endtask

    task step(input string tag);
        @(posedge c);
        modelEdge();
        #1;
        checkAll(tag);
    endtask

    // Asynchronous reset a little after an edge; outputs must clear at once.
    task doReset(input string tag);
        r = 1'b1;
        #1;
        modelReset();
        checkAll(tag);
        check({tag, ".gnt0"}, 32'(gnt), 32'h0);
        check({tag, ".q0"},   32'(q),   32'h0);
        #2;
        r = 1'b0;
    endtask

    initial begin
        r = 1'b1; req = '0; d = '0;
        modelReset();
        #12;
        checkAll("por");
        r = 1'b0;

        // Reset asserted mid-cycle while everyone requests
        req = 4'b1111; d = 32'h13121110;
        step("pre_reset");
        doReset("reset_mid");
        step("first_after_reset");
        check("first_after_reset.gnt0", 32'(gnt), 32'h1);

        // Single requester, then it drops
        doReset("reset_single");
        req = 4'b0100; d = 32'h00A50000;
        step("single");
        check("single.q_a5", 32'(q), 32'hA5);
        req = 4'b0000;
        step("single_drop");
        step("idle");

        // Full contention from ptr=0; long enough to cross a scrub slot
        doReset("reset_contend");
        req = 4'b1111; d = 32'h13121110;
        for (int i = 0; i < 12; i++) step("contend");

        // Wrap from ptr=0 after a grant to requester 3
        req = 4'b1000;
        step("wrap_prep");
        req = 4'b1001;
        step("wrap_a");
        step("wrap_b");

        // Reset in the middle of a grant
        req = 4'b1111;
        step("grant_before_reset");
        doReset("reset_mid_grant");

        // Randomized traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            req = 4'($urandom_range(0, 15));
            d = $urandom;
            if ($urandom_range(0, 60) == 0) doReset("rand_reset");
            else step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
